data_mem_arbiter: RTL and testbench
===================================

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 16, address width of the requester ports and the memory port.
REQ-002 Parameter: DATA_W, default 16, data width of store and load data.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port: req0_valid  input  1  requester 0 (CPU) has an access pending.
REQ-006 Port: req0_write  input  1  requester 0 access type (1 = store, 0 = load).
REQ-007 Port: req0_addr  input  ADDR_W  requester 0 address.
REQ-008 Port: req0_wdata  input  DATA_W  requester 0 store data.
REQ-009 Port: req0_ready  output  1  requester 0 access accepted this cycle.
REQ-010 Port: rsp0_valid  output  1  one-cycle completion pulse for requester 0.
REQ-011 Ports: req1_valid, req1_write, req1_addr, req1_wdata, req1_ready, rsp1_valid; same as REQ-005..REQ-010 but for requester 1 (DMA/debug).
REQ-012 Port: rsp_rdata  output  DATA_W  load data of the most recent completed load, shared by both requesters.
REQ-013 Ports: mem_address (output, ADDR_W), mem_store_data (output, DATA_W), mem_memRead (output, 1), mem_memWrite (output, 1); drive the data memory.
REQ-014 Port: mem_load_data  input  DATA_W  combinational read data returned by the memory.

Function
REQ-015 FSM: two states, IDLE and ACCESS.
REQ-016 IDLE, no reqN_valid: stay in IDLE; both ready signals low.
REQ-017 IDLE, exactly one reqN_valid: assert reqN_ready combinationally in that cycle, latch write/addr/wdata and the grant id, then go to ACCESS.
REQ-018 IDLE, both valid: grant the requester that is not last_grant; latch it as in REQ-017 and update last_grant to the winner.
REQ-019 Ready: at most one reqN_ready is high in any cycle; both are low in ACCESS.
REQ-020 ACCESS, load: assert mem_memRead for exactly one cycle and capture mem_load_data into rsp_rdata at the end of that cycle.
REQ-021 ACCESS, store: assert mem_memWrite for exactly one cycle; the memory writes on the rising edge that ends ACCESS.
REQ-022 ACCESS always returns to IDLE after one cycle.
REQ-023 mem_address and mem_store_data come from the latched registers and hold their value outside ACCESS.
REQ-024 mem_memRead and mem_memWrite are low outside ACCESS and are never high together.
REQ-025 Completion: rspN_valid of the granted requester pulses high for one cycle, the cycle after ACCESS, for both loads and stores.
REQ-026 Latency and throughput: accept in cycle T, ACCESS in T+1, rspN_valid in T+2; at most one access per 2 cycles.
REQ-027 Overlap: a new request may be accepted in the same IDLE cycle in which the previous rspN_valid pulses.
REQ-028 rsp_rdata is updated only by load completions; stores leave it unchanged.
REQ-029 Requesters hold valid, write, addr and wdata stable until ready; the arbiter samples them only in the cycle ready is high.
REQ-030 Dropping reqN_valid before ready is legal; no access is issued for that request.

Reset
REQ-031 While rst_n is low, immediately and asynchronously: state=IDLE, last_grant=1 (requester 0 wins the first tie), latched addr/wdata/write=0, rsp_rdata=0.
REQ-032 While rst_n is low, all of the following are low: ready, rsp_valid, mem_memRead, mem_memWrite, mem_address and mem_store_data.
REQ-033 Reset asserted during ACCESS drops mem_memWrite before the next edge, so no write occurs, and the pending rsp_valid pulse is cancelled.
REQ-034 After rst_n deasserts, the first rising edge with a valid request is handled as IDLE.

Verification
REQ-035 Single store then load, req0: store addr 0x0010 data 0xBEEF -> ready T, mem_memWrite T+1, rsp0_valid T+2. Then load 0x0010 -> rsp_rdata=0xBEEF with rsp0_valid.
REQ-036 Tie: both valid from reset, req0 load 0x0001, req1 load 0x0002 -> req0 granted first, req1 granted 2 cycles later. Next tie -> req0 then req1 alternate in grant order.
REQ-037 Back-to-back: req1 holds valid for 4 stores -> ready every second cycle, rsp1_valid coincides with the next ready, 4 memory writes.
REQ-038 Reset mid-store: rst_n low during ACCESS of store 0x0020 <- 0x1234 -> mem_memWrite falls at once, no rsp pulse, a later load of 0x0020 returns the prior contents.
REQ-039 Withdrawn request: req1_valid high one cycle while req0 is in ACCESS, then low -> no req1 grant, no memory access for req1.
REQ-040 Invariants checked every cycle: ready one-hot-or-zero; memRead and memWrite never both high; each ready is followed by exactly one rsp_valid two cycles later.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: two-requester round-robin arbiter in front of a single-port data memory.
// Each access takes one ACCESS cycle; completion pulses on the following cycle.
module data_mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              rsp0_valid,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_store_data,
  output logic              mem_memRead,
  output logic              mem_memWrite,
  input  logic [DATA_W-1:0] mem_load_data
);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rsp_q, rsp_d;
  logic              idle, take0, take1, accept;
  always_comb begin
    // rst_n gates ready so nothing is accepted while reset is held
    idle         = rst_n && (state_q == IDLE);
    take0        = idle && req0_valid && (!req1_valid || last_grant_q);
    take1        = idle && req1_valid && (!req0_valid || !last_grant_q);
    accept       = take0 || take1;
    state_d      = accept ? ACCESS : IDLE;
    last_grant_d = accept ? take1 : last_grant_q;
    write_d      = take0 ? req0_write : take1 ? req1_write : write_q;
    addr_d       = take0 ? req0_addr  : take1 ? req1_addr  : addr_q;
    wdata_d      = take0 ? req0_wdata : take1 ? req1_wdata : wdata_q;
    rsp_d        = (state_q == ACCESS);
    rdata_d      = (state_q == ACCESS && !write_q) ? mem_load_data : rdata_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      rsp_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      rsp_q        <= rsp_d;
    end
  end
  // last_grant_q doubles as the id of the access currently completing
  assign req0_ready     = take0;
  assign req1_ready     = take1;
  assign rsp0_valid     = rsp_q && !last_grant_q;
  assign rsp1_valid     = rsp_q && last_grant_q;
  assign rsp_rdata      = rdata_q;
  assign mem_address    = addr_q;
  assign mem_store_data = wdata_q;
  assign mem_memRead    = (state_q == ACCESS) && !write_q;
  assign mem_memWrite   = (state_q == ACCESS) && write_q;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed self-checking bench with a behavioural data memory.
module tb_data_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid = 0, req0_write = 0, req1_valid = 0, req1_write = 0;
  logic [15:0] req0_addr = '0, req0_wdata = '0, req1_addr = '0, req1_wdata = '0;
  logic        req0_ready, rsp0_valid, req1_ready, rsp1_valid;
  logic [15:0] rsp_rdata, mem_address, mem_store_data, mem_load_data;
  logic        mem_memRead, mem_memWrite;
  logic [15:0] mem [256];
  int          errs = 0, checks = 0, wr_cnt = 0, wc0;
  logic [1:0]  h0 = '0, h1 = '0;

  data_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready), .rsp0_valid(rsp0_valid),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready), .rsp1_valid(rsp1_valid),
    .rsp_rdata(rsp_rdata), .mem_address(mem_address), .mem_store_data(mem_store_data),
    .mem_memRead(mem_memRead), .mem_memWrite(mem_memWrite), .mem_load_data(mem_load_data)
  );

  always #5 clk = ~clk;
  assign mem_load_data = mem[mem_address[7:0]];
  always @(posedge clk) if (mem_memWrite) mem[mem_address[7:0]] <= mem_store_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      h0 = '0;
      h1 = '0;
    end else begin
      chk("ready_onehot", {31'b0, req0_ready & req1_ready}, 0);
      chk("rd_wr_excl", {31'b0, mem_memRead & mem_memWrite}, 0);
      chk("rsp0_follow", {31'b0, rsp0_valid}, {31'b0, h0[1]});
      chk("rsp1_follow", {31'b0, rsp1_valid}, {31'b0, h1[1]});
      h0 = {h0[0], req0_ready};
      h1 = {h1[0], req1_ready};
      if (mem_memWrite) wr_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit id, input logic v, input logic w, input logic [15:0] a, input logic [15:0] d);
    if (id) begin
      req1_valid = v; req1_write = w; req1_addr = a; req1_wdata = d;
    end else begin
      req0_valid = v; req0_write = w; req0_addr = a; req0_wdata = d;
    end
  endtask

  task automatic xfer(input bit id, input logic w, input logic [15:0] a, input logic [15:0] d,
                      input logic [15:0] exp_rd);
    step();
    drive(id, 1'b1, w, a, d);
    @(negedge clk);
    chk("xfer_ready", {31'b0, id ? req1_ready : req0_ready}, 1);
    chk("xfer_ready_other", {31'b0, id ? req0_ready : req1_ready}, 0);
    chk("xfer_no_mem", {30'b0, mem_memRead, mem_memWrite}, 0);
    step();
    drive(id, 1'b0, w, a, d);
    @(negedge clk);
    chk("xfer_mem_wr", {31'b0, mem_memWrite}, {31'b0, w});
    chk("xfer_mem_rd", {31'b0, mem_memRead}, {31'b0, !w});
    chk("xfer_mem_addr", {16'b0, mem_address}, {16'b0, a});
    if (w) chk("xfer_mem_wdata", {16'b0, mem_store_data}, {16'b0, d});
    step();
    @(negedge clk);
    chk("xfer_rsp", {31'b0, id ? rsp1_valid : rsp0_valid}, 1);
    chk("xfer_rdata", {16'b0, rsp_rdata}, {16'b0, exp_rd});
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #2;
    chk("rst_ready0", {31'b0, req0_ready}, 0);
    chk("rst_ready1", {31'b0, req1_ready}, 0);
    chk("rst_rsp", {30'b0, rsp0_valid, rsp1_valid}, 0);
    chk("rst_mem_ctl", {30'b0, mem_memRead, mem_memWrite}, 0);
    chk("rst_mem_addr", {16'b0, mem_address}, 0);
    chk("rst_mem_wdata", {16'b0, mem_store_data}, 0);
    chk("rst_rdata", {16'b0, rsp_rdata}, 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
    rst_n = 1'b1;
    // store then load on requester 0
    xfer(0, 1, 16'h0010, 16'hBEEF, 16'h0000);
    xfer(0, 0, 16'h0010, 16'h0000, 16'hBEEF);
    xfer(1, 1, 16'h0001, 16'h1111, 16'hBEEF);
    xfer(1, 1, 16'h0002, 16'h2222, 16'hBEEF);
    xfer(0, 1, 16'h0020, 16'h5555, 16'hBEEF);
    // ties from reset alternate req0 first
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int r = 0; r < 2; r++) begin
      step();
      drive(0, 1, 0, 16'h0001, 16'h0);
      drive(1, 1, 0, 16'h0002, 16'h0);
      @(negedge clk);
      chk("tie_first_r0", {30'b0, req0_ready, req1_ready}, 2);
      step();
      req0_valid = 1'b0;
      @(negedge clk);
      chk("tie_wait_r1", {31'b0, req1_ready}, 0);
      chk("tie_addr0", {16'b0, mem_address}, 16'h0001);
      chk("tie_rd0", {31'b0, mem_memRead}, 1);
      step();
      @(negedge clk);
      chk("tie_second_r1", {30'b0, req0_ready, req1_ready}, 1);
      chk("tie_rsp0", {31'b0, rsp0_valid}, 1);
      chk("tie_rdata0", {16'b0, rsp_rdata}, 16'h1111);
      step();
      req1_valid = 1'b0;
      @(negedge clk);
      chk("tie_addr1", {16'b0, mem_address}, 16'h0002);
      step();
      @(negedge clk);
      chk("tie_rsp1", {31'b0, rsp1_valid}, 1);
      chk("tie_rdata1", {16'b0, rsp_rdata}, 16'h2222);
    end
    // back-to-back stores from requester 1
    wc0 = wr_cnt;
    step();
    drive(1, 1, 1, 16'h0040, 16'hA000);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("b2b_ready", {31'b0, req1_ready}, 1);
      chk("b2b_rsp_overlap", {31'b0, rsp1_valid}, (k > 0) ? 1 : 0);
      step();
      if (k < 3) drive(1, 1, 1, 16'h0041 + 16'(k), 16'hA001 + 16'(k));
      else req1_valid = 1'b0;
      @(negedge clk);
      chk("b2b_access_ready", {31'b0, req1_ready}, 0);
      chk("b2b_wr", {31'b0, mem_memWrite}, 1);
      chk("b2b_addr", {16'b0, mem_address}, {16'b0, 16'h0040 + 16'(k)});
      step();
    end
    @(negedge clk);
    chk("b2b_last_rsp", {31'b0, rsp1_valid}, 1);
    chk("b2b_wr_count", wr_cnt - wc0, 4);
    chk("b2b_mem43", {16'b0, mem[8'h43]}, 16'hA003);
    chk("b2b_rdata_kept", {16'b0, rsp_rdata}, 16'h2222);
    // reset during a store's ACCESS cycle
    step();
    drive(0, 1, 1, 16'h0020, 16'h1234);
    @(negedge clk);
    chk("rst_mid_ready", {31'b0, req0_ready}, 1);
    step();
    req0_valid = 1'b0;
    #2;
    chk("rst_mid_wr_before", {31'b0, mem_memWrite}, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_wr_drop", {31'b0, mem_memWrite}, 0);
    chk("rst_mid_addr", {16'b0, mem_address}, 0);
    chk("rst_mid_rdata", {16'b0, rsp_rdata}, 0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_no_rsp", {30'b0, rsp0_valid, rsp1_valid}, 0);
    xfer(0, 0, 16'h0020, 16'h0000, 16'h5555);
    // requester 1 withdraws while requester 0 is in ACCESS
    step();
    drive(0, 1, 0, 16'h0010, 16'h0);
    @(negedge clk);
    chk("wd_ready0", {31'b0, req0_ready}, 1);
    step();
    req0_valid = 1'b0;
    drive(1, 1, 0, 16'h0030, 16'h0);
    @(negedge clk);
    chk("wd_r1_blocked", {31'b0, req1_ready}, 0);
    chk("wd_addr", {16'b0, mem_address}, 16'h0010);
    step();
    req1_valid = 1'b0;
    @(negedge clk);
    chk("wd_rsp0", {31'b0, rsp0_valid}, 1);
    chk("wd_rdata", {16'b0, rsp_rdata}, 16'hBEEF);
    chk("wd_r1_none", {31'b0, req1_ready}, 0);
    step();
    @(negedge clk);
    chk("wd_no_rsp1", {31'b0, rsp1_valid}, 0);
    chk("wd_no_mem", {30'b0, mem_memRead, mem_memWrite}, 0);
    chk("wd_addr_hold", {16'b0, mem_address}, 16'h0010);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
